hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline interlock controller for the 5-stage core (IF, OF, EX, MA, RW plus the write-back latch). It keeps a scoreboard of destination registers in flight downstream of OF. On a read-after-write hazard it freezes IF/OF and injects a bubble into EX. On a taken branch it squashes the wrong-path instruction. It also keeps saturating stall and flush counters for performance debug.

## Interface

Parameters:
- `NREG_W`, default 4: register-address width (16 architectural registers).
- `DEPTH`, default 4: scoreboard entries. These are the stages a writer occupies before its result is readable in OF: EX, MA, RW, WB latch.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `of_valid`, input, 1: the OF stage holds a real instruction.
- `of_src1`, input, NREG_W: first source register.
- `of_src1_used`, input, 1: `of_src1` is actually read.
- `of_src2`, input, NREG_W: second source register (rd for st, ra for ret).
- `of_src2_used`, input, 1: `of_src2` is actually read.
- `of_dst`, input, NREG_W: destination register (ra for call).
- `of_wb`, input, 1: the OF instruction writes `of_dst`.
- `ex_branch_taken`, input, 1: the branch in EX is taken this cycle.
- `cnt_clr`, input, 1: synchronous clear of both counters.
- `stall_if`, output, 1: hold the PC and the IF/OF register (combinational).
- `bubble_ex`, output, 1: load a NOP, with all control bits 0, into the OF/EX register (combinational).
- `flush_of`, output, 1: load a NOP into the IF/OF register (combinational).
- `state`, output, 2: registered action of the previous cycle. 0 = RUN, 1 = STALL, 2 = FLUSH.
- `stall_cnt`, output, CNT_W: cycles spent stalled, saturating.
- `flush_cnt`, output, CNT_W: taken-branch flushes, saturating.

## Operation

- **Scoreboard:** a shift register of DEPTH entries `{v, dst}`. Entry 0 corresponds to EX and entry DEPTH-1 to the WB latch. It advances every cycle; there is no freeze, because the downstream stages never stall.
- **Entry 0 load:**
  - `{1, of_dst}` when `of_valid & of_wb & ~stall_if & ~flush_of`.
  - `{0, x}` otherwise.
- **Hazard:** `haz = of_valid & ((of_src1_used & match(of_src1)) | (of_src2_used & match(of_src2)))`. `match(r)` is true when any entry has `v=1` and `dst==r`.
- **Priority:**
  1. **FLUSH**, when `ex_branch_taken`: drive `flush_of=1`, `bubble_ex=1`, `stall_if=0`. Any hazard on the squashed OF instruction is ignored.
  2. **STALL**, when `haz`: drive `stall_if=1`, `bubble_ex=1`, `flush_of=0`.
  3. **RUN**: all three outputs 0.
- **FSM:** `state` registers the action chosen above each cycle. Any state may move to any other state. FLUSH always lasts exactly one cycle per taken branch.
- **Counters:**
  - `stall_cnt` increments on each STALL cycle.
  - `flush_cnt` increments on each FLUSH cycle.
  - Both saturate at 2^CNT_W−1.
  - `cnt_clr` has priority over an increment in the same cycle.
- **Write to r0:** no special case. It is tracked like any other register.

## Timing

- `stall_if`, `bubble_ex` and `flush_of` are combinational from the inputs and scoreboard state, with zero latency.
- `state` and the counters update on the rising edge.
- Back-to-back dependent pair: exactly DEPTH stall cycles. The consumer issues on the cycle the producer's entry shifts out of entry DEPTH-1.
- Dependency at distance k (k−1 independent instructions between): max(0, DEPTH−k+1) stall cycles.
- Stall length is bounded by DEPTH. A longer run of STALL is a bug.
- **Reset asserted (low):**
  - All scoreboard `v` bits clear.
  - `state`=RUN, counters=0.
  - The combinational outputs settle to 0 unless `ex_branch_taken` is high.
- **Reset mid-stall:** the stall releases immediately, because the scoreboard is empty.

## Structure

- Shared package `pipe_pkg`:
  - the state encodings `ST_RUN`, `ST_STALL`, `ST_FLUSH`;
  - `REG_RA` = 15;
  - the NOP instruction constant used by `flush_of` and `bubble_ex` consumers.
- One sub-module, `sb_match`: a DEPTH-entry comparator returning `match` for one source address. It is instantiated twice.
- Scoreboard and counters live in `hazard_ctrl`.

## Test plan

- **RAW back-to-back:** `add r1` then `sub r2,r1,r3` → `stall_if=1` and `bubble_ex=1` for exactly 4 cycles; `stall_cnt`=4; the consumer issues on cycle 5.
- **Distance 3:** writer r5, two independent instructions, then a reader of r5 → exactly 2 stall cycles.
- **Unused source:** `of_src2_used=0`, `of_src2` matches an in-flight dst → no stall.
- **Branch during stall:** hazard present and `ex_branch_taken=1` in the same cycle → `flush_of=1`, `bubble_ex=1`, `stall_if=0`; `state`=FLUSH next cycle; `flush_cnt`=1.
- **Saturation and clear:** with CNT_W=4, force 20 stall cycles → `stall_cnt`=15. Then assert `cnt_clr` alongside a stall → `stall_cnt`=0.
- **Async reset:** pull `reset` low mid-stall between edges → `stall_if` drops without waiting for a clock edge; all outputs 0; the scoreboard is empty after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: interlock action encodings, special registers
// and the NOP used when a stage register is squashed or bubbled.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int unsigned REG_RA = 15;

  // All-zero word: no write-back, no memory access, no branch.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Taken branch outranks a hazard; the squashed instruction's hazard is moot.
  function automatic state_t pick_action(input logic branch_taken, input logic haz);
    if (branch_taken)
      return ST_FLUSH;
    else if (haz)
      return ST_STALL;
    else
      return ST_RUN;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one source address against every valid scoreboard entry.
module sb_match #(
  parameter int unsigned NREG_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [DEPTH-1:0]             v,
  input  logic [DEPTH-1:0][NREG_W-1:0] dst,
  input  logic [NREG_W-1:0]            addr,
  output logic                         match
);

  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (v[i] && (dst[i] == addr))
        match = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: RAW scoreboard, stall/bubble/flush generation and
// saturating performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NREG_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              of_valid,
  input  logic [NREG_W-1:0] of_src1,
  input  logic              of_src1_used,
  input  logic [NREG_W-1:0] of_src2,
  input  logic              of_src2_used,
  input  logic [NREG_W-1:0] of_dst,
  input  logic              of_wb,
  input  logic              ex_branch_taken,
  input  logic              cnt_clr,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_of,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]             sb_v;
  logic [DEPTH-1:0][NREG_W-1:0] sb_dst;
  logic                         match1;
  logic                         match2;
  logic                         haz;
  logic                         load_v;
  state_t                       action;
  state_t                       state_q;

  sb_match #(
    .NREG_W (NREG_W),
    .DEPTH  (DEPTH)
  ) u_match1 (
    .v     (sb_v),
    .dst   (sb_dst),
    .addr  (of_src1),
    .match (match1)
  );

  sb_match #(
    .NREG_W (NREG_W),
    .DEPTH  (DEPTH)
  ) u_match2 (
    .v     (sb_v),
    .dst   (sb_dst),
    .addr  (of_src2),
    .match (match2)
  );

  always_comb begin
    haz       = of_valid & ((of_src1_used & match1) | (of_src2_used & match2));
    action    = pick_action(ex_branch_taken, haz);
    flush_of  = (action == ST_FLUSH);
    stall_if  = (action == ST_STALL);
    bubble_ex = (action != ST_RUN);
    load_v    = of_valid & of_wb & ~stall_if & ~flush_of;
  end

  // Downstream stages never stall, so the scoreboard shifts unconditionally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_v   <= '0;
      sb_dst <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_dst[i] <= sb_dst[i-1];
      end
      sb_v[0]   <= load_v;
      sb_dst[0] <= of_dst;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= action;
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if ((action == ST_STALL) && (stall_cnt != CNT_MAX))
          stall_cnt <= stall_cnt + 1'b1;
        if ((action == ST_FLUSH) && (flush_cnt != CNT_MAX))
          flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule
